// File: rtl/sky_lsu.sv
// Load/store unit driving a single-port word memory with 1-cycle read latency.
// Sub-word stores have no byte enables available, so they are done as read-modify-write.
module sky_lsu #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter bit          ADDR_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic [1:0]  resp_error_o,
    output logic [31:0] mem_address_o,
    output logic        mem_read_en_o,
    output logic        mem_write_en_o,
    output logic [31:0] mem_write_data_o,
    input  logic [31:0] mem_read_data_i,
    output logic [2:0]  dbg_state_o
);
    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never depends combinationally on ready, and payload holds while valid && !ready.
    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [29:0] widx_q, widx_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic [31:0] word_q, word_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  err_q, err_d;

    logic [1:0]  acc_err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_val;
    logic [31:0] merged;

    always_comb begin
        acc_err = 2'd0;
        if (req_size_i == 2'd3) begin
            acc_err = 2'd3;
        end else if ((req_size_i == 2'd1 && req_addr_i[0]) ||
                     (req_size_i == 2'd2 && req_addr_i[1:0] != 2'd0)) begin
            acc_err = 2'd1;
        end else if (ADDR_CHECK && req_addr_i[31:2] >= MEM_WORDS_W) begin
            acc_err = 2'd2;
        end
    end

    // Lane extraction for loads and lane merge for RMW stores, both from the read word.
    always_comb begin
        rd_byte = mem_read_data_i[{lane_q, 3'b000} +: 8];
        rd_half = lane_q[1] ? mem_read_data_i[31:16] : mem_read_data_i[15:0];
        case (size_q)
            2'd0:    ld_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'd1:    ld_val = {{16{signed_q & rd_half[15]}}, rd_half};
            default: ld_val = mem_read_data_i;
        endcase
        merged = mem_read_data_i;
        if (size_q == 2'd0) begin
            merged[{lane_q, 3'b000} +: 8] = word_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = word_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        lane_d   = lane_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        word_d   = word_q;
        data_d   = data_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    widx_d   = ADDR_CHECK ? req_addr_i[31:2] : req_addr_i[31:2] % MEM_WORDS_W;
                    lane_d   = req_addr_i[1:0];
                    size_d   = req_size_i;
                    signed_d = req_signed_i;
                    write_d  = req_write_i;
                    word_d   = req_wdata_i;
                    data_d   = 32'd0;
                    err_d    = acc_err;
                    if (acc_err != 2'd0) begin
                        state_d = RESP;
                    end else if (req_write_i && req_size_i == 2'd2) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: state_d = RD_WAIT;
            RD_WAIT: begin
                if (write_q) begin
                    word_d  = merged;
                    state_d = WR;
                end else begin
                    data_d  = ld_val;
                    state_d = RESP;
                end
            end
            WR: state_d = RESP;
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            widx_q   <= 30'd0;
            lane_q   <= 2'd0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            word_q   <= 32'd0;
            data_q   <= 32'd0;
            err_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            widx_q   <= widx_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            word_q   <= word_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign req_ready_o      = (state_q == IDLE);
    assign resp_valid_o     = (state_q == RESP);
    assign resp_data_o      = data_q;
    assign resp_error_o     = err_q;
    assign mem_read_en_o    = (state_q == RD);
    assign mem_write_en_o   = (state_q == WR);
    assign mem_address_o    = (state_q == RD || state_q == RD_WAIT || state_q == WR) ?
                              {widx_q, 2'b00} : 32'd0;
    assign mem_write_data_o = (state_q == WR) ? word_q : 32'd0;
    assign dbg_state_o      = 3'(state_q);

endmodule

// File: tb/tb_sky_lsu.sv
// Bench for sky_lsu: directed steps then random traffic, checked against a byte-level memory model.
module tb_sky_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [1:0]  resp_error;
    logic [31:0] mem_address, mem_write_data;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_read_data;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        init_mem = 1'b1;
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [31:0] last_addr = 32'd0;

    logic        pend_w;
    logic [1:0]  pend_sz;
    logic        pend_sg;
    logic [31:0] pend_a, pend_wd;

    sky_lsu #(.MEM_WORDS(1024), .ADDR_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_size_i(req_size), .req_signed_i(req_signed),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_error_o(resp_error),
        .mem_address_o(mem_address), .mem_read_en_o(mem_read_en),
        .mem_write_en_o(mem_write_en), .mem_write_data_o(mem_write_data),
        .mem_read_data_i(mem_read_data), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory responder: 1-cycle read data, garbage on the read bus when not reading.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
        end
        if (mem_read_en && mem_write_en) both_cnt <= both_cnt + 1;
        if (mem_read_en) begin
            rd_cnt        <= rd_cnt + 1;
            last_addr     <= mem_address;
            mem_read_data <= mem[mem_address[11:2]];
        end else begin
            mem_read_data <= $urandom();
        end
        if (mem_write_en) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= mem_address;
            mem[mem_address[11:2]] <= mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_err(input logic [1:0] sz, input logic [31:0] a);
        int unsigned nb;
        if (sz == 2'd3) return 2'd3;
        nb = 1 << sz;
        if (a % nb != 0) return 2'd1;
        if (a / 4 >= 1024) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        int unsigned nb, sh;
        longint unsigned v, span;
        nb   = 1 << sz;
        sh   = 8 * (a % 4);
        span = 64'd1 << (8 * nb);
        v    = ({32'd0, ref_mem[a[11:2]]} >> sh) % span;
        if (sg && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic void m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int unsigned sh;
        longint unsigned mask, w;
        sh   = 8 * (a % 4);
        mask = ((64'd1 << (8 * (1 << sz))) - 1) << sh;
        w    = {32'd0, ref_mem[a[11:2]]};
        w    = (w & ~mask) | (({32'd0, wd} << sh) & mask);
        ref_mem[a[11:2]] = w[31:0];
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_data"}, resp_data, 32'd0);
        chk({tag, "_resp_error"}, 32'(resp_error), 32'd0);
        chk({tag, "_mem_read_en"}, 32'(mem_read_en), 32'd0);
        chk({tag, "_mem_write_en"}, 32'(mem_write_en), 32'd0);
        chk({tag, "_mem_address"}, mem_address, 32'd0);
        chk({tag, "_mem_write_data"}, mem_write_data, 32'd0);
    endtask

    // One transaction. early: fields already presented, don't wait for negedge.
    // pend: during the hold cycles present the pend_* request to show it is refused.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int hold, input bit early, input bit pend);
        logic [1:0]  e_err, s_err;
        logic [31:0] e_data, s_data;
        int e_lat, e_rd, e_wr, lat, rd0, wr0;
        e_err = m_err(sz, a);
        e_data = 32'd0; e_rd = 0; e_wr = 0;
        if (e_err != 2'd0) begin
            e_lat = 1;
        end else if (!w) begin
            e_data = m_load(sz, sg, a); e_lat = 3; e_rd = 1;
        end else begin
            m_store(sz, a, wd); e_wr = 1;
            if (sz == 2'd2) e_lat = 2;
            else begin e_lat = 4; e_rd = 1; end
        end
        if (!early) @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom()); req_size = 2'($urandom());
        req_signed = 1'($urandom()); req_addr = $urandom(); req_wdata = $urandom();
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("resp_data", resp_data, e_data);
        chk("resp_error", 32'(resp_error), 32'(e_err));
        chk("read_strobes", 32'(rd_cnt - rd0), 32'(e_rd));
        chk("write_strobes", 32'(wr_cnt - wr0), 32'(e_wr));
        chk("mem_address_resp", mem_address, 32'd0);
        if (e_rd + e_wr > 0) chk("strobe_address", last_addr, {a[31:2], 2'b00});
        s_data = resp_data; s_err = resp_error;
        for (int i = 0; i < hold; i++) begin
            if (pend) begin
                req_valid = 1'b1; req_write = pend_w; req_size = pend_sz;
                req_signed = pend_sg; req_addr = pend_a; req_wdata = pend_wd;
            end
            @(posedge clk); #1;
            chk("hold_resp_valid", 32'(resp_valid), 32'd1);
            chk("hold_resp_data", resp_data, s_data);
            chk("hold_resp_error", 32'(resp_error), 32'(s_err));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
        chk("post_strobes", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'(e_rd + e_wr));
    endtask

    initial begin
        int rd0, wr0, mism, r, off;
        logic [1:0] sz;
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        init_mem = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("idle");

        // Word store then word load.
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0);

        // Byte RMW and byte loads.
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, 0, 1'b0, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'hCAFE5580 & 32'h000000FF, 0, 1'b0, 1'b0);
        chk("rmw_word", mem[64], 32'h11228044);
        do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 0, 1'b0, 1'b0);
        do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 0, 1'b0, 1'b0);
        do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'hFFFFA5C3, 1, 1'b0, 1'b0);
        chk("rmw_half", mem[64], 32'hA5C38044);

        // Half loads and a misaligned half.
        do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h80011234, 0, 1'b0, 1'b0);
        do_req(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 0, 1'b0, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 32'h200, 32'h0, 0, 1'b0, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 32'h203, 32'h0, 0, 1'b0, 1'b0);

        // Range and size errors.
        do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 1'b0, 1'b0);
        do_req(1'b0, 2'd3, 1'b0, 32'h1001, 32'h0, 0, 1'b0, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 32'h202, 32'h12345678, 0, 1'b0, 1'b0);

        // Backpressure with a pending request, accepted the cycle after the handshake.
        pend_w = 1'b0; pend_sz = 2'd2; pend_sg = 1'b0; pend_a = 32'h200; pend_wd = 32'h0;
        do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 5, 1'b0, 1'b1);
        do_req(pend_w, pend_sz, pend_sg, pend_a, pend_wd, 0, 1'b1, 1'b0);

        // Reset during RD_WAIT of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h105; req_wdata = 32'h000000AB;
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("mid_rmw_reset");
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("reset_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("reset_one_read", 32'(rd_cnt - rd0), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 0, 1'b0, 1'b0);

        // Random traffic.
        for (int t = 0; t < 80; t++) begin
            r = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            off = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) off = off & ~((1 << sz) - 1);
            do_req(1'($urandom()), sz, 1'($urandom()),
                   32'($urandom_range(0, 1100)) * 4 + 32'(off), $urandom(),
                   int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_image_mismatches", 32'(mism), 32'd0);
        chk("strobes_overlap", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/sky_lsu.md
Name: sky_lsu

Overview:
- Load/store unit. It is the initiator on the single-port data-memory interface: word address, read/write enables, 1-cycle registered read data.
- Accepts one load or store request from the memory pipeline stage over a valid/ready handshake.
- Handles byte, half and word sizes. There are no byte enables on the memory, so sub-word stores use read-modify-write.
- Returns aligned, zero- or sign-extended load data, or an error code, over a valid/ready response channel.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words behind the interface; the word index must be < MEM_WORDS.
- ADDR_CHECK, 1: 1 = report out-of-range accesses as errors; 0 = no range check, index wraps modulo MEM_WORDS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = invalid
- req_signed  in  1  sign-extend load data
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_data  out  32  load result; 0 for stores and errors
- resp_error  out  2  0 = ok, 1 = misaligned, 2 = out of range, 3 = invalid size
- mem_address  out  32  word-aligned byte address ({addr[31:2],2'b00})
- mem_read_en  out  1  read strobe
- mem_write_en  out  1  write strobe
- mem_write_data  out  32  write word
- mem_read_data  in  32  valid the cycle after mem_read_en

Behaviour:
- Endianness: little-endian. Byte lane = addr[1:0]; half lane = addr[1].
- States: IDLE, RD, RD_WAIT, WR, RESP. req_ready=1 only in IDLE.
- Accept: in IDLE, req_valid && req_ready latches the request.
- Error check at accept, priority order: invalid size (3) > misaligned (1) > out of range (2).
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr[31:2] >= MEM_WORDS, checked only when ADDR_CHECK=1.
  - Error path: go to RESP with resp_error set; no memory strobe is ever issued.
- Next state from IDLE: load -> RD; word store -> WR; byte/half store -> RD (RMW).
- RD: mem_read_en=1 for exactly one cycle -> RD_WAIT.
- RD_WAIT: sample mem_read_data.
  - Load: extract the lane, extend per req_signed, register into resp_data -> RESP.
  - RMW store: merge the req_wdata low byte/half into the lane -> WR.
- WR: mem_write_en=1 for exactly one cycle; mem_write_data = full word (word store) or merged word (RMW) -> RESP.
- RESP: resp_valid=1; resp_data and resp_error hold stable until resp_ready. On handshake -> IDLE. req_ready rises the next cycle; no request is accepted in the handshake cycle.
- Latency, accept cycle = 0, resp_valid first asserted at:
  - error: 1
  - word store: 2
  - load: 3
  - sub-word store: 4
- Strobes: mem_read_en and mem_write_en are never asserted together. mem_address is held at the latched word address in RD, RD_WAIT and WR; it is 0 in IDLE and RESP.
- Store response: resp_data=0, resp_error=0.
- Reset (any state, including mid-RMW): next state IDLE, with
  - req_ready=1
  - resp_valid=0, resp_data=0, resp_error=0
  - mem_read_en=0, mem_write_en=0, mem_address=0, mem_write_data=0
  - No pending write is issued after reset deasserts. The latched request is discarded.
- req_* inputs are ignored outside the IDLE accept cycle. mem_read_data is ignored outside RD_WAIT.

Test Plan:
- Word store 0xDEADBEEF @0x100, then word load @0x100 -> one mem_write_en pulse with mem_address 0x100; resp_valid 2 cycles after store accept; load resp_data 0xDEADBEEF, 3 cycles after accept, resp_error 0.
- Memory word @0x100 = 0x11223344; byte store 0x80 @0x101 -> RD, RD_WAIT, WR sequence; written word 0x11228044. Signed byte load @0x101 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Word @0x200 = 0x80011234:
  - signed half load @0x202 -> 0xFFFF8001
  - unsigned half load @0x200 -> 0x00001234
  - half load @0x203 -> resp_error 1 after 1 cycle, mem_read_en never asserted
- With ADDR_CHECK=1, MEM_WORDS=1024:
  - word load @0x1000 -> resp_error 2, no strobes
  - req_size 3 @0x1001 -> resp_error 3, since invalid size wins
- Hold resp_ready low 5 cycles after a load -> resp_valid, resp_data and resp_error stable, req_ready 0, a pending req_valid not accepted; accepted in the cycle after the handshake.
- Assert reset during RD_WAIT of a byte store -> mem_write_en never asserts; all outputs at reset values the next cycle; a fresh word load completes normally afterwards.
